// File: rtl/div_nat_seq_if.sv
// Handshake bundle for div_nat_seq.
//   request : in_valid / in_ready, dividend (N+M bits), divisor (N bits)
//   response: out_valid / out_ready, q (M bits), r (N bits), ow
// master modport is the requester/consumer side, slave is the divider.
interface div_nat_seq_if #(
   parameter int N = 8,
   parameter int M = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N+M-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [M-1:0]   q;
   logic [N-1:0]   r;
   logic           ow;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, q, r, ow
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, q, r, ow
   );
endinterface

// File: rtl/div_nat_seq.sv
// Sequential restoring divider for naturals: dividend = divisor*q + r, r < divisor.
// One quotient bit per clock, valid/ready handshake on both sides.
// Ports:
//   clock  - system clock, rising edge
//   reset_ - synchronous active-low reset
//   bus    - div_nat_seq_if.slave (in_valid/in_ready/dividend/divisor,
//            out_valid/out_ready/q/r/ow)
// Optional build macro DIV_ROUND_NEAREST_EN: round the quotient to nearest
// (one extra ROUND cycle, saturates with ow=1 when q is already all ones).
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// CALC  | one restoring step per edge, M edges total
// ROUND | optional round-to-nearest adjust (DIV_ROUND_NEAREST_EN only)
// DONE  | result presented, held until out_ready
module div_nat_seq #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic          clock,
   input  logic          reset_,
   div_nat_seq_if.slave  bus
);
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      DONE  = 2'd2,
      ROUND = 2'd3
   } state_t;

   state_t         state, state_nx;
   logic [N-1:0]   x_reg, x_nx;
   logic [N-1:0]   r_reg, r_nx;
   logic [M-1:0]   q_reg, q_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           ow_reg, ow_nx;
   logic [N:0]     t_val;
   logic [N-1:0]   r_sub;
   logic           err;

   always_ff @(posedge clock) begin
      if (!reset_) begin
         state  <= IDLE;
         x_reg  <= '0;
         r_reg  <= '0;
         q_reg  <= '0;
         cnt    <= '0;
         ow_reg <= 1'b0;
      end else begin
         state  <= state_nx;
         x_reg  <= x_nx;
         r_reg  <= r_nx;
         q_reg  <= q_nx;
         cnt    <= cnt_nx;
         ow_reg <= ow_nx;
      end
   end

   always_comb begin
      state_nx = state;
      x_nx     = x_reg;
      r_nx     = r_reg;
      q_nx     = q_reg;
      cnt_nx   = cnt;
      ow_nx    = ow_reg;
      // Partial remainder shifted left with the next dividend bit from Q's MSB.
      t_val    = {r_reg, q_reg[M-1]};
      // The true difference always fits in N bits, so modulo-N subtraction is exact.
      r_sub    = t_val[N-1:0] - x_reg;
      // Quotient overflows M bits exactly when the upper dividend half >= divisor.
      err      = (bus.divisor == '0) || (bus.dividend[N+M-1:M] >= bus.divisor);

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               x_nx = bus.divisor;
               if (err) begin
                  q_nx     = '1;
                  r_nx     = '0;
                  ow_nx    = 1'b1;
                  state_nx = DONE;
               end else begin
                  r_nx     = bus.dividend[N+M-1:M];
                  q_nx     = bus.dividend[M-1:0];
                  cnt_nx   = CW'(M - 1);
                  ow_nx    = 1'b0;
                  state_nx = CALC;
               end
            end
         end
         CALC: begin
            if (t_val >= {1'b0, x_reg}) begin
               r_nx = r_sub;
               q_nx = {q_reg[M-2:0], 1'b1};
            end else begin
               r_nx = t_val[N-1:0];
               q_nx = {q_reg[M-2:0], 1'b0};
            end
            cnt_nx = cnt - CW'(1);
            if (cnt == '0) begin
`ifdef DIV_ROUND_NEAREST_EN
               state_nx = ROUND;
`else
               state_nx = DONE;
`endif
            end
         end
`ifdef DIV_ROUND_NEAREST_EN
         ROUND: begin
            // 2r >= X means the fractional part is at least one half.
            if ({r_reg, 1'b0} >= {1'b0, x_reg}) begin
               if (&q_reg) begin
                  ow_nx = 1'b1;
               end else begin
                  q_nx = q_reg + M'(1);
               end
            end
            state_nx = DONE;
         end
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   // Working registers are only exposed while a finished result is presented.
   assign bus.q         = (state == DONE) ? q_reg  : '0;
   assign bus.r         = (state == DONE) ? r_reg  : '0;
   assign bus.ow        = (state == DONE) ? ow_reg : 1'b0;
endmodule

// File: tb/tb_div_nat_seq.sv
module tb_div_nat_seq;
   localparam int N = 8;
   localparam int M = 8;
`ifdef DIV_ROUND_NEAREST_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clock;
   logic reset_;
   int   n_chk;
   int   n_fail;

   div_nat_seq_if #(.N(N), .M(M)) bus ();

   div_nat_seq #(.N(N), .M(M)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: plain integer division; edge count includes the accept edge.
   function automatic void model(input logic [15:0] d, input logic [7:0] x,
                                 output logic [7:0] eq, output logic [7:0] er,
                                 output logic eow, output int elat);
      int dd = int'(d);
      int xx = int'(x);
      int qq;
      int rr;
      if (xx == 0 || (dd / 256) >= xx) begin
         eq = 8'hFF; er = 8'h00; eow = 1'b1; elat = 1;
      end else begin
         qq = dd / xx;
         rr = dd % xx;
         eow = 1'b0;
         elat = M + 1;
         if (RND) begin
            elat = M + 2;
            if (2 * rr >= xx) begin
               if (qq == 255) eow = 1'b1;
               else qq = qq + 1;
            end
         end
         eq = 8'(qq);
         er = 8'(rr);
      end
   endfunction

   task automatic run_op(input logic [15:0] d, input logic [7:0] x, input int stall);
      logic [7:0] eq, er, hq, hr;
      logic       eow, how;
      int         elat, lat, w;
      model(d, x, eq, er, eow, elat);
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(posedge clock); #1;
         w++;
      end
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.out_ready = (stall == 0);
      bus.in_valid  = 1'b1;
      bus.dividend  = d;
      bus.divisor   = x;
      @(posedge clock); #1;
      bus.in_valid  = 1'b0;
      bus.dividend  = 16'($urandom);
      bus.divisor   = 8'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(elat));
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("q", 32'(bus.q), 32'(eq));
      chk("r", 32'(bus.r), 32'(er));
      chk("ow", 32'(bus.ow), 32'(eow));
      hq = bus.q; hr = bus.r; how = bus.ow;
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.dividend = 16'($urandom);
         bus.divisor  = 8'($urandom);
         @(posedge clock); #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_q", 32'(bus.q), 32'(hq));
         chk("hold_r", 32'(bus.r), 32'(hr));
         chk("hold_ow", 32'(bus.ow), 32'(how));
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      chk("release_valid", 32'(bus.out_valid), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic check_reset_state();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_r", 32'(bus.r), 32'd0);
      chk("rst_ow", 32'(bus.ow), 32'd0);
   endtask

   initial begin
      logic [7:0]  x;
      logic [15:0] d;
      n_chk = 0;
      n_fail = 0;
      reset_ = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_state();
      reset_ = 1'b1;

      run_op(16'd1000, 8'd7, 0);
      run_op(16'hFEFF, 8'hFF, 0);
      run_op(16'h1234, 8'd0, 0);
      run_op(16'h0800, 8'd8, 0);
      run_op(16'h5678, 8'h99, 5);
      run_op(16'h0000, 8'd1, 0);
      run_op(16'h00AB, 8'd1, 0);
      run_op(16'h01AB, 8'd1, 0);
      run_op(16'd51199, 8'd200, 2);
      run_op(16'd51200, 8'd200, 0);
      run_op(16'hFFFF, 8'hFF, 1);

      // Abort mid-CALC: reset asserted at the 4th iteration edge.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.dividend  = 16'h3C21;
      bus.divisor   = 8'h7F;
      @(posedge clock); #1;
      bus.in_valid  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_ = 1'b0;
      @(posedge clock); #1;
      check_reset_state();
      reset_ = 1'b1;
      run_op(16'd200, 8'd9, 0);

      for (int k = 0; k < 1500; k++) begin
         x = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) d = 16'($urandom);
         else d = 16'($urandom_range(0, (int'(x) * 256 > 0) ? int'(x) * 256 - 1 : 0));
         run_op(d, x, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
